// File: rtl/fifo_arb_pkg.sv
// Shared sizing constants and the round-robin pick helper for the FIFO write arbiter.
package fifo_arb_pkg;

  localparam int FIFO_DEPTH = 8;
  localparam int FIFO_W     = 8;
  localparam int CNT_W      = 4;

  // Widest requester set the pick helper supports, and the index width that covers it.
  localparam int RR_MAX_N = 8;
  localparam int RR_IDX_W = 3;

  // One-hot grant for the first set bit of req[n-1:0], searching upward from ptr with wrap.
  function automatic logic [RR_MAX_N-1:0] rr_pick(
    input logic [RR_MAX_N-1:0] req,
    input logic [RR_IDX_W-1:0] ptr,
    input int                  n
  );
    logic [RR_MAX_N-1:0] gnt;
    logic                found;
    logic [RR_IDX_W-1:0] idx;
    gnt   = '0;
    found = 1'b0;
    for (int i = 0; i < RR_MAX_N; i++) begin
      idx = RR_IDX_W'((int'(ptr) + i) % n);
      if ((i < n) && !found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
    return gnt;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_arbiter.sv
// Round-robin picker: combinational grant over req, pointer advances past the winner when adv is set.
// Zero-latency pick; the caller decides (via adv) whether the grant was actually taken.
module rr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int N = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N-1:0]        req,
  input  logic                adv,
  output logic [N-1:0]        gnt,
  output logic [RR_IDX_W-1:0] gnt_idx,
  output logic                gnt_any
);

  logic [RR_IDX_W-1:0] rr_ptr_q;
  logic [RR_IDX_W-1:0] rr_ptr_d;
  logic [RR_MAX_N-1:0] req_ext;
  logic [RR_MAX_N-1:0] pick;

  always_comb begin
    req_ext        = '0;
    req_ext[N-1:0] = req;
    pick           = rr_pick(req_ext, rr_ptr_q, N);
    gnt_any        = |pick;
    gnt_idx        = '0;
    for (int i = 0; i < RR_MAX_N; i++) begin
      if (pick[i]) begin
        gnt_idx = RR_IDX_W'(i);
      end
    end
    gnt = '0;
    for (int i = 0; i < N; i++) begin
      gnt[i] = gnt_any && (gnt_idx == RR_IDX_W'(i));
    end
  end

  // Kept apart from the pick so adv (derived from gnt_any upstream) forms no combinational loop.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (adv && gnt_any) begin
      rr_ptr_d = (gnt_idx == RR_IDX_W'(N - 1)) ? '0 : gnt_idx + RR_IDX_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin sharing of one FIFO write port; ACK/FIFO_WEN one cycle after REQ is sampled, no writes on full.
// Optional FIFO_ARB_STATS_EN adds per-requester saturating GRANT_CNT and a registered STALL flag.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int N     = 4,
  parameter int W     = FIFO_W,
  parameter int DEPTH = FIFO_DEPTH,
  parameter int CW    = CNT_W
) (
  input  logic           CLK,
  input  logic           RST_N,
  input  logic [N-1:0]   REQ,
  input  logic [N*W-1:0] WDATA,
  output logic [N-1:0]   ACK,
  output logic           FIFO_WEN,
  output logic [W-1:0]   FIFO_WDATA,
  input  logic           FIFO_REN,
  output logic [CW-1:0]  COUNT,
  output logic           FULL,
  output logic           EMPTY
`ifdef FIFO_ARB_STATS_EN
  ,
  output logic [N*8-1:0] GRANT_CNT,
  output logic           STALL
`endif
);

  logic [N-1:0]        gnt;
  logic [RR_IDX_W-1:0] gnt_idx;
  logic                gnt_any;
  logic                space;
  logic                grant;
  logic                rd_dec;
  logic [W-1:0]        wdata_a [RR_MAX_N];

  logic [N-1:0]  ack_q, ack_d;
  logic          fifo_wen_q, fifo_wen_d;
  logic [W-1:0]  fifo_wdata_q, fifo_wdata_d;
  logic [CW-1:0] count_q, count_d;

  rr_arbiter #(.N(N)) u_rr (
    .clk     (CLK),
    .rst_n   (RST_N),
    .req     (REQ),
    .adv     (grant),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );

  for (genvar g = 0; g < RR_MAX_N; g++) begin : g_wdata
    if (g < N) begin : g_on
      assign wdata_a[g] = WDATA[g*W +: W];
    end else begin : g_off
      assign wdata_a[g] = '0;
    end
  end

  // The in-flight write counts against space; reads are ignored so a full FIFO is never overrun.
  always_comb begin
    space  = ({1'b0, count_q} + {{CW{1'b0}}, fifo_wen_q}) < (CW+1)'(DEPTH);
    grant  = gnt_any && space;
    rd_dec = FIFO_REN && (count_q != '0);

    ack_d        = grant ? gnt : '0;
    fifo_wen_d   = grant;
    fifo_wdata_d = grant ? wdata_a[gnt_idx] : fifo_wdata_q;
    count_d      = count_q + {{(CW-1){1'b0}}, fifo_wen_q} - {{(CW-1){1'b0}}, rd_dec};
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ack_q        <= '0;
      fifo_wen_q   <= 1'b0;
      fifo_wdata_q <= '0;
      count_q      <= '0;
    end else begin
      ack_q        <= ack_d;
      fifo_wen_q   <= fifo_wen_d;
      fifo_wdata_q <= fifo_wdata_d;
      count_q      <= count_d;
    end
  end

  assign ACK        = ack_q;
  assign FIFO_WEN   = fifo_wen_q;
  assign FIFO_WDATA = fifo_wdata_q;
  assign COUNT      = count_q;
  assign FULL       = (count_q == CW'(DEPTH));
  assign EMPTY      = (count_q == '0);

`ifdef FIFO_ARB_STATS_EN
  logic [N-1:0][7:0] grant_cnt_q, grant_cnt_d;
  logic              stall_q, stall_d;

  always_comb begin
    grant_cnt_d = grant_cnt_q;
    for (int i = 0; i < N; i++) begin
      if (ack_d[i] && (grant_cnt_q[i] != 8'hFF)) begin
        grant_cnt_d[i] = grant_cnt_q[i] + 8'd1;
      end
    end
    stall_d = gnt_any && !space;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      grant_cnt_q <= '0;
      stall_q     <= 1'b0;
    end else begin
      grant_cnt_q <= grant_cnt_d;
      stall_q     <= stall_d;
    end
  end

  assign GRANT_CNT = grant_cnt_q;
  assign STALL     = stall_q;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed scenarios with literal expectations, then randomized traffic
// checked every cycle against an integer/queue model of the arbitration and occupancy rules.
module tb_fifo_wr_arbiter;

  localparam int N     = 4;
  localparam int W     = 8;
  localparam int DEPTH = 8;
  localparam int CW    = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req;
  logic [N*W-1:0] wdata;
  logic [N-1:0]   ack;
  logic           fifo_wen;
  logic [W-1:0]   fifo_wdata;
  logic           ren;
  logic [CW-1:0]  count;
  logic           full;
  logic           empty;
`ifdef FIFO_ARB_STATS_EN
  logic [N*8-1:0] grant_cnt;
  logic           stall;
`endif

  always #5 clk = ~clk;

  fifo_wr_arbiter #(.N(N), .W(W), .DEPTH(DEPTH), .CW(CW)) dut (
    .CLK        (clk),
    .RST_N      (rst_n),
    .REQ        (req),
    .WDATA      (wdata),
    .ACK        (ack),
    .FIFO_WEN   (fifo_wen),
    .FIFO_WDATA (fifo_wdata),
    .FIFO_REN   (ren),
    .COUNT      (count),
    .FULL       (full),
    .EMPTY      (empty)
`ifdef FIFO_ARB_STATS_EN
    ,
    .GRANT_CNT  (grant_cnt),
    .STALL      (stall)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int           m_count = 0;
  logic         m_wen   = 1'b0;
  logic [N-1:0] m_ack   = '0;
  logic [W-1:0] m_wdata = '0;
  int           m_ptr   = 0;
  int           m_gcnt[N];
  logic         m_stall = 1'b0;

  function automatic int pick(input logic [N-1:0] r, input int ptr);
    int idx;
    for (int i = 0; i < N; i++) begin
      idx = (ptr + i) % N;
      if (r[idx]) return idx;
    end
    return 0;
  endfunction

  function automatic bit has_space(input int cnt, input logic inflight);
    return (cnt + int'(inflight)) < DEPTH;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_count <= 0;
      m_wen   <= 1'b0;
      m_ack   <= '0;
      m_wdata <= '0;
      m_ptr   <= 0;
      m_stall <= 1'b0;
      for (int i = 0; i < N; i++) m_gcnt[i] <= 0;
    end else begin
      if (req != '0 && has_space(m_count, m_wen)) begin
        m_wen   <= 1'b1;
        m_ack   <= N'(1) << pick(req, m_ptr);
        m_wdata <= wdata[pick(req, m_ptr)*W +: W];
        m_ptr   <= (pick(req, m_ptr) + 1) % N;
        if (m_gcnt[pick(req, m_ptr)] < 255) m_gcnt[pick(req, m_ptr)] <= m_gcnt[pick(req, m_ptr)] + 1;
      end else begin
        m_wen <= 1'b0;
        m_ack <= '0;
      end
      m_count <= m_count + int'(m_wen) - ((ren && m_count != 0) ? 1 : 0);
      m_stall <= (req != '0) && !has_space(m_count, m_wen);
    end
  end

  // FIFO stand-in fed by the DUT, and the model's view of the same FIFO.
  logic [W-1:0] fq[$];
  logic [W-1:0] expq[$];
  logic [W-1:0] last_rd = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fq.delete();
      expq.delete();
    end else begin
      if (ren) begin
        if (fq.size() > 0 && expq.size() > 0) check("fifo_rd_data", 32'(fq[0]), 32'(expq[0]));
        if (fq.size() > 0) begin
          last_rd <= fq[0];
          void'(fq.pop_front());
        end
        if (expq.size() > 0) void'(expq.pop_front());
      end
      if (fifo_wen) begin
        check("fifo_no_overflow", 32'(fq.size() < DEPTH), 32'd1);
        fq.push_back(fifo_wdata);
      end
      if (m_wen) expq.push_back(m_wdata);
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("ack",        32'(ack),        32'(m_ack));
      check("fifo_wen",   32'(fifo_wen),   32'(m_wen));
      check("fifo_wdata", 32'(fifo_wdata), 32'(m_wdata));
      check("count",      32'(count),      32'(m_count));
      check("full",       32'(full),       32'(m_count == DEPTH));
      check("empty",      32'(empty),      32'(m_count == 0));
`ifdef FIFO_ARB_STATS_EN
      for (int i = 0; i < N; i++) check("grant_cnt", 32'(grant_cnt[i*8 +: 8]), 32'(m_gcnt[i]));
      check("stall", 32'(stall), 32'(m_stall));
`endif
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Requesters that were just acknowledged present a fresh word (REQ stays high).
  task automatic refresh_acked();
    for (int i = 0; i < N; i++) begin
      if (ack[i]) wdata[i*W +: W] = 8'($urandom);
    end
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  function automatic int oh2idx(input logic [N-1:0] oh);
    for (int i = 0; i < N; i++) if (oh[i]) return i;
    return -1;
  endfunction

  initial begin
    int          n_ack;
    logic [31:0] order;
    int          first_idx;
    bit          found;
    int          ren_pct;

    rst_n = 1'b1;
    req   = '0;
    wdata = '0;
    ren   = 1'b0;
    #1 rst_n = 1'b0;
    #10;
    check("rst_ack",        32'(ack),        32'd0);
    check("rst_fifo_wen",   32'(fifo_wen),   32'd0);
    check("rst_fifo_wdata", 32'(fifo_wdata), 32'd0);
    check("rst_count",      32'(count),      32'd0);
    check("rst_full",       32'(full),       32'd0);
    check("rst_empty",      32'(empty),      32'd1);
`ifdef FIFO_ARB_STATS_EN
    check("rst_grant_cnt",  grant_cnt,       32'd0);
    check("rst_stall",      32'(stall),      32'd0);
`endif
    #11 rst_n = 1'b1;
    step();

    // Single word from requester 0.
    req = 4'b0001;
    wdata[7:0] = 8'hA5;
    step();
    check("t2_ack",        32'(ack),        32'h1);
    check("t2_fifo_wen",   32'(fifo_wen),   32'd1);
    check("t2_fifo_wdata", 32'(fifo_wdata), 32'hA5);
    check("t2_count_0",    32'(count),      32'd0);
    req = '0;
    step();
    check("t2_count_1",    32'(count),      32'd1);
    check("t2_wen_drop",   32'(fifo_wen),   32'd0);
    ren = 1'b1;
    step();
    ren = 1'b0;
    check("t2_readback",   32'(last_rd),    32'hA5);
    check("t2_empty",      32'(empty),      32'd1);

    // All four requesting: round-robin order, stop at full.
    pulse_reset();
    req = 4'b1111;
    for (int i = 0; i < N; i++) wdata[i*W +: W] = 8'(8'h10 * (i + 1));
    n_ack = 0;
    order = '0;
    for (int c = 0; c < 16; c++) begin
      step();
      if (ack != '0) begin
        n_ack++;
        order = (order << 4) | 32'(oh2idx(ack));
      end
      refresh_acked();
    end
    check("t3_n_acks",  32'(n_ack), 32'd8);
    check("t3_order",   order,      32'h01230123);
    check("t3_count",   32'(count), 32'd8);
    check("t3_full",    32'(full),  32'd1);
`ifdef FIFO_ARB_STATS_EN
    check("t3_grant_cnt", grant_cnt,   32'h02020202);
    check("t3_stall",     32'(stall),  32'd1);
`endif

    // One read while full frees one slot; exactly one more grant, to requester 0.
    ren = 1'b1;
    step();
    ren = 1'b0;
    check("t4_count_7", 32'(count), 32'd7);
    n_ack = 0;
    first_idx = -1;
    for (int c = 0; c < 6; c++) begin
      step();
      if (ack != '0) begin
        n_ack++;
        if (first_idx < 0) first_idx = oh2idx(ack);
      end
      refresh_acked();
    end
    check("t4_n_acks",  32'(n_ack),     32'd1);
    check("t4_winner",  32'(first_idx), 32'd0);
    check("t4_count_8", 32'(count),     32'd8);

    // Simultaneous write and read at COUNT=4.
    req = '0;
    pulse_reset();
    req = 4'b0001;
    wdata[7:0] = 8'h3C;
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      step();
      refresh_acked();
      if (count == 4 && fifo_wen) found = 1'b1;
    end
    check("t5_reached_count4", 32'(found), 32'd1);
    ren = 1'b1;
    req = '0;
    step();
    check("t5_count_wr_rd", 32'(count), 32'd4);
    ren = 1'b0;
    step();
    check("t5_count_hold",  32'(count), 32'd4);

    // Read while empty, then reset in the middle of a burst.
    pulse_reset();
    ren = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      check("t6_count_empty_rd", 32'(count), 32'd0);
      check("t6_empty_rd",       32'(empty), 32'd1);
    end
    ren = 1'b0;
    req = 4'b1111;
    for (int c = 0; c < 3; c++) begin
      step();
      refresh_acked();
    end
    check("t6_count_pre_rst", 32'(count), 32'd2);
    #2 rst_n = 1'b0;
    #1;
    check("t6_async_ack",   32'(ack),        32'd0);
    check("t6_async_wen",   32'(fifo_wen),   32'd0);
    check("t6_async_wdata", 32'(fifo_wdata), 32'd0);
    check("t6_async_count", 32'(count),      32'd0);
    check("t6_async_empty", 32'(empty),      32'd1);
    #2 rst_n = 1'b1;
    step();
    check("t6_first_after_rst", 32'(ack), 32'h1);
    refresh_acked();

    // Randomized traffic under light, medium and heavy read load.
    for (int ph = 0; ph < 3; ph++) begin
      ren_pct = (ph == 0) ? 10 : (ph == 1) ? 45 : 85;
      for (int c = 0; c < 800; c++) begin
        step();
        for (int i = 0; i < N; i++) begin
          if (ack[i]) begin
            if ($urandom_range(0, 3) == 0) req[i] = 1'b0;
            else wdata[i*W +: W] = 8'($urandom);
          end else if (!req[i] && $urandom_range(0, 2) == 0) begin
            req[i] = 1'b1;
            wdata[i*W +: W] = 8'($urandom);
          end
        end
        ren = ($urandom_range(0, 99) < ren_pct);
      end
    end
    ren = 1'b0;
    req = '0;
    step();
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
